// File: rtl/adj_job_arbiter_if.sv
// Bundles the requester-facing and core-facing signals of the job arbiter.
// slave is the arbiter's view; master is the surrounding system (requesters plus core).
interface adj_job_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [12*N-1:0] reqAin;
  logic [12*N-1:0] reqBin;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [11:0]     result;
  logic            err;
  logic            busy;
  logic            coreStart;
  logic            coreAck;
  logic            coreReset;
  logic [11:0]     coreAin;
  logic [11:0]     coreBin;
  logic            coreQi;
  logic            coreQc;
  logic            coreQd;
  logic [11:0]     coreA;

  modport slave (
    input  req, reqAin, reqBin, coreQi, coreQc, coreQd, coreA,
    output grant, done, result, err, busy, coreStart, coreAck, coreReset, coreAin, coreBin
  );

  modport master (
    output req, reqAin, reqBin, coreQi, coreQc, coreQd, coreA,
    input  grant, done, result, err, busy, coreStart, coreAck, coreReset, coreAin, coreBin
  );
endinterface

// File: rtl/adj_job_arbiter.sv
// Round-robin scheduler for one shared 12-bit adjust core: grants a requester, launches
// the job, returns the core result, and aborts hung jobs through a dedicated core reset.
module adj_job_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 256,
  parameter int CW      = 9
) (
  input logic               i_clk,
  input logic               i_rst,
  adj_job_arbiter_if.slave  io_bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ACK,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_grant;
  logic [N-1:0]   r_done;
  logic [11:0]    r_result;
  logic           r_err;
  logic           r_busy;
  logic           r_coreStart;
  logic           r_coreAck;
  logic           r_coreReset;
  logic [11:0]    r_coreAin;
  logic [11:0]    r_coreBin;

  state_t         w_stateNext;
  logic [PW-1:0]  w_ptrNext;
  logic [CW-1:0]  w_cntNext;
  logic [N-1:0]   w_grantNext;
  logic [N-1:0]   w_doneNext;
  logic [11:0]    w_resultNext;
  logic           w_errNext;
  logic           w_busyNext;
  logic           w_coreStartNext;
  logic           w_coreAckNext;
  logic           w_coreResetNext;
  logic [11:0]    w_coreAinNext;
  logic [11:0]    w_coreBinNext;

  logic           w_found;
  logic [PW-1:0]  w_idx;
  logic [PW:0]    w_sum;
  logic [PW-1:0]  w_cand;
  logic           w_unusedQc;

  // The core's ADJ indication carries no information the arbiter needs.
  assign w_unusedQc = io_bus.coreQc;

  // Search from the round-robin pointer upward, wrapping modulo N; first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && io_bus.req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_ptrNext       = r_ptr;
    w_cntNext       = r_cnt;
    w_grantNext     = r_grant;
    w_doneNext      = '0;
    w_resultNext    = r_result;
    w_errNext       = 1'b0;
    w_coreStartNext = 1'b0;
    w_coreAckNext   = 1'b0;
    w_coreResetNext = 1'b0;
    w_coreAinNext   = r_coreAin;
    w_coreBinNext   = r_coreBin;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grantNext     = N'(1) << w_idx;
          w_coreAinNext   = io_bus.reqAin[int'(w_idx)*12 +: 12];
          w_coreBinNext   = io_bus.reqBin[int'(w_idx)*12 +: 12];
          w_ptrNext       = (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;
          w_coreStartNext = 1'b1;
          w_cntNext       = '0;
          w_stateNext     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        w_cntNext = r_cnt + 1'b1;
        // Completion is checked first so a job finishing on the last allowed cycle is not aborted.
        if (io_bus.coreQd) begin
          w_resultNext  = io_bus.coreA;
          w_doneNext    = r_grant;
          w_coreAckNext = 1'b1;
          w_stateNext   = S_ACK;
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          w_coreResetNext = 1'b1;
          w_doneNext      = r_grant;
          w_errNext       = 1'b1;
          w_stateNext     = S_ABORT;
        end
      end
      S_ACK: begin
        if (io_bus.coreQi) begin
          w_grantNext = '0;
          w_stateNext = S_IDLE;
        end
      end
      S_ABORT: begin
        w_stateNext = S_DRAIN;
      end
      S_DRAIN: begin
        if (io_bus.coreQi) begin
          w_grantNext = '0;
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_grantNext = '0;
        w_stateNext = S_IDLE;
      end
    endcase

    w_busyNext = (w_stateNext != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_coreStart <= 1'b0;
      r_coreAck   <= 1'b0;
      r_coreReset <= 1'b0;
      r_coreAin   <= '0;
      r_coreBin   <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_ptr       <= w_ptrNext;
      r_cnt       <= w_cntNext;
      r_grant     <= w_grantNext;
      r_done      <= w_doneNext;
      r_result    <= w_resultNext;
      r_err       <= w_errNext;
      r_busy      <= w_busyNext;
      r_coreStart <= w_coreStartNext;
      r_coreAck   <= w_coreAckNext;
      r_coreReset <= w_coreResetNext;
      r_coreAin   <= w_coreAinNext;
      r_coreBin   <= w_coreBinNext;
    end
  end

  assign io_bus.grant     = r_grant;
  assign io_bus.done      = r_done;
  assign io_bus.result    = r_result;
  assign io_bus.err       = r_err;
  assign io_bus.busy      = r_busy;
  assign io_bus.coreStart = r_coreStart;
  assign io_bus.coreAck   = r_coreAck;
  assign io_bus.coreReset = r_coreReset;
  assign io_bus.coreAin   = r_coreAin;
  assign io_bus.coreBin   = r_coreBin;

endmodule

// File: tb/tb_adj_job_arbiter.sv
// Directed bench for adj_job_arbiter with a behavioural adjust core and a manual core override.
module tb_adj_job_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adj_job_arbiter_if #(.N(N)) ifc ();

  adj_job_arbiter #(.N(N), .TIMEOUT(256), .CW(9)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (ifc)
  );

  // Behavioural core: +100 while below target, -10 while above, DONE on equality.
  typedef enum logic [1:0] {C_INI, C_ADJ, C_DONE} coreState_e;
  coreState_e coreState;
  logic [11:0] coreAcc;
  logic [11:0] coreTgt;
  logic coreRstAll;
  logic manualCore = 1'b0;
  logic mQi = 1'b0;
  logic mQd = 1'b0;
  logic [11:0] mA = '0;

  assign coreRstAll = rst | ifc.coreReset;

  always @(posedge clk or posedge coreRstAll) begin
    if (coreRstAll) begin
      coreState <= C_INI;
      coreAcc   <= '0;
      coreTgt   <= '0;
    end else begin
      case (coreState)
        C_INI: if (ifc.coreStart) begin
          coreAcc   <= ifc.coreAin;
          coreTgt   <= ifc.coreBin;
          coreState <= C_ADJ;
        end
        C_ADJ: begin
          if (coreAcc == coreTgt) coreState <= C_DONE;
          else if (coreAcc < coreTgt) coreAcc <= coreAcc + 12'd100;
          else coreAcc <= coreAcc - 12'd10;
        end
        C_DONE: if (ifc.coreAck) coreState <= C_INI;
        default: coreState <= C_INI;
      endcase
    end
  end

  assign ifc.coreQi = manualCore ? mQi  : (coreState == C_INI);
  assign ifc.coreQc = manualCore ? 1'b0 : (coreState == C_ADJ);
  assign ifc.coreQd = manualCore ? mQd  : (coreState == C_DONE);
  assign ifc.coreA  = manualCore ? mA   : coreAcc;

  int startCnt = 0;
  int resetCnt = 0;
  int doneCnt = 0;
  int onehotErr = 0;
  int adj200Cnt = 0;

  always @(negedge clk) begin
    if (ifc.coreStart) startCnt++;
    if (ifc.coreReset) resetCnt++;
    if (|ifc.done) doneCnt++;
    if (ifc.grant != '0 && !$onehot(ifc.grant)) onehotErr++;
    if (!manualCore && coreState == C_ADJ && coreAcc == 12'd200) adj200Cnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] reqMask);
    ifc.req = reqMask;
  endtask

  task automatic setOperands(input int idx, input logic [11:0] a, input logic [11:0] b);
    ifc.reqAin[idx*12 +: 12] = a;
    ifc.reqBin[idx*12 +: 12] = b;
  endtask

  task automatic waitDone(input int maxCyc, output logic [N-1:0] d,
                          output logic [11:0] res, output logic e);
    logic seen;
    seen = 1'b0;
    d = '0;
    res = '0;
    e = 1'b0;
    for (int c = 0; c < maxCyc && !seen; c++) begin
      @(negedge clk);
      if (|ifc.done) begin
        seen = 1'b1;
        d = ifc.done;
        res = ifc.result;
        e = ifc.err;
      end
    end
    if (!seen) checkOutput("doneSeen", 32'(seen), 32'd1);
  endtask

  task automatic waitIdle(input int maxCyc);
    logic idle;
    idle = 1'b0;
    for (int c = 0; c < maxCyc && !idle; c++) begin
      @(negedge clk);
      if (!ifc.busy) idle = 1'b1;
    end
    checkOutput("idleReached", 32'(idle), 32'd1);
  endtask

  task automatic waitStart(input int maxCyc);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < maxCyc && !seen; c++) begin
      @(negedge clk);
      if (ifc.coreStart) seen = 1'b1;
    end
    checkOutput("startSeen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [N-1:0] d;
    logic [11:0] res;
    logic e;
    int snapStart, snapReset, snapDone, snap200;
    int n0, n1;
    int order [5] = '{0, 1, 2, 3, 0};

    ifc.req = '0;
    ifc.reqAin = '0;
    ifc.reqBin = '0;

    // Reset state
    #2;
    checkOutput("rstCtrl", 32'({ifc.grant, ifc.done, ifc.err, ifc.busy,
                                ifc.coreStart, ifc.coreAck, ifc.coreReset}), 32'd0);
    checkOutput("rstData", 32'({ifc.result, ifc.coreAin, ifc.coreBin}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin with all requesting: 0,1,2,3,0
    $display("[TB] round-robin sweep");
    for (int i = 0; i < N; i++) setOperands(i, 12'd5, 12'd5);
    snapStart = startCnt;
    snapDone = doneCnt;
    applyStimulus(4'b1111);
    for (int j = 0; j < 5; j++) begin
      waitDone(50, d, res, e);
      checkOutput($sformatf("rrDone%0d", j), 32'(d), 32'(4'b0001 << order[j]));
      checkOutput($sformatf("rrGrant%0d", j), 32'(ifc.grant), 32'(4'b0001 << order[j]));
      if (j == 4) applyStimulus(4'b0000);
    end
    waitIdle(50);
    checkOutput("rrDoneCount", 32'(doneCnt - snapDone), 32'd5);
    checkOutput("rrStartCount", 32'(startCnt - snapStart), 32'd5);
    checkOutput("rrOnehot", 32'(onehotErr), 32'd0);

    // Simple job on requester 0: 100 -> 200 -> 300
    $display("[TB] job 0: 100 to 300");
    setOperands(0, 12'd100, 12'd300);
    snapStart = startCnt;
    snap200 = adj200Cnt;
    applyStimulus(4'b0001);
    waitDone(50, d, res, e);
    applyStimulus(4'b0000);
    checkOutput("j0Done", 32'(d), 32'h1);
    checkOutput("j0Result", 32'(res), 32'd300);
    checkOutput("j0Err", 32'(e), 32'd0);
    @(negedge clk);
    checkOutput("j0DonePulse", 32'(ifc.done), 32'd0);
    waitIdle(50);
    checkOutput("j0GrantClr", 32'(ifc.grant), 32'd0);
    checkOutput("j0StartOnce", 32'(startCnt - snapStart), 32'd1);
    checkOutput("j0Visit200", 32'(adj200Cnt - snap200 > 0), 32'd1);

    // Overshoot then step down: 100,200,300,290..250
    $display("[TB] job 1: overshoot to 250");
    setOperands(1, 12'd100, 12'd250);
    applyStimulus(4'b0010);
    waitDone(50, d, res, e);
    applyStimulus(4'b0000);
    checkOutput("j1Done", 32'(d), 32'h2);
    checkOutput("j1Result", 32'(res), 32'd250);
    checkOutput("j1Err", 32'(e), 32'd0);
    waitIdle(50);

    // Timeout abort on requester 2
    $display("[TB] job 2: timeout abort");
    setOperands(2, 12'd4000, 12'd4090);
    applyStimulus(4'b0100);
    n0 = -1;
    n1 = -1;
    for (int c = 0; c < 400 && n1 < 0; c++) begin
      @(negedge clk);
      if (ifc.coreStart) n0 = c;
      if (ifc.coreReset) begin
        n1 = c;
        d = ifc.done;
        e = ifc.err;
        res = ifc.result;
      end
    end
    applyStimulus(4'b0000);
    checkOutput("toSeen", 32'(n1 >= 0 && n0 >= 0), 32'd1);
    checkOutput("toLatency", 32'(n1 - n0), 32'd257);
    checkOutput("toDone", 32'(d), 32'h4);
    checkOutput("toErr", 32'(e), 32'd1);
    checkOutput("toResultKept", 32'(res), 32'd250);
    waitIdle(50);
    setOperands(0, 12'd20, 12'd20);
    applyStimulus(4'b0001);
    waitDone(50, d, res, e);
    applyStimulus(4'b0000);
    checkOutput("postToDone", 32'(d), 32'h1);
    checkOutput("postToResult", 32'(res), 32'd20);
    checkOutput("postToErr", 32'(e), 32'd0);
    waitIdle(50);

    // Reset in the middle of requester 3's job
    $display("[TB] reset mid-job");
    setOperands(3, 12'd100, 12'd300);
    applyStimulus(4'b1000);
    waitStart(20);
    repeat (2) @(negedge clk);
    checkOutput("midBusy", 32'(ifc.busy), 32'd1);
    checkOutput("midGrant", 32'(ifc.grant), 32'h8);
    rst = 1'b1;
    #1;
    checkOutput("midRstCtrl", 32'({ifc.grant, ifc.done, ifc.err, ifc.busy,
                                   ifc.coreStart, ifc.coreAck, ifc.coreReset}), 32'd0);
    checkOutput("midRstData", 32'({ifc.result, ifc.coreAin, ifc.coreBin}), 32'd0);
    setOperands(0, 12'd7, 12'd7);
    applyStimulus(4'b1001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitDone(50, d, res, e);
    applyStimulus(4'b1000);
    checkOutput("postRstFirst", 32'(d), 32'h1);
    checkOutput("postRstResult0", 32'(res), 32'd7);
    waitDone(50, d, res, e);
    applyStimulus(4'b0000);
    checkOutput("postRstSecond", 32'(d), 32'h8);
    checkOutput("postRstResult3", 32'(res), 32'd300);
    waitIdle(50);

    // Completion on the final allowed WAIT cycle beats the timeout
    $display("[TB] completion at timeout boundary");
    manualCore = 1'b1;
    mQi = 1'b1;
    mQd = 1'b0;
    mA = 12'h000;
    snapReset = resetCnt;
    setOperands(0, 12'd1, 12'd1);
    applyStimulus(4'b0001);
    waitStart(20);
    mQi = 1'b0;
    repeat (256) @(negedge clk);
    mQd = 1'b1;
    mA = 12'h5A5;
    @(negedge clk);
    applyStimulus(4'b0000);
    checkOutput("edgeDone", 32'(ifc.done), 32'h1);
    checkOutput("edgeErr", 32'(ifc.err), 32'd0);
    checkOutput("edgeResult", 32'(ifc.result), 32'h5A5);
    checkOutput("edgeAck", 32'(ifc.coreAck), 32'd1);
    mQd = 1'b0;
    mQi = 1'b1;
    waitIdle(20);
    checkOutput("edgeNoCoreReset", 32'(resetCnt - snapReset), 32'd0);
    manualCore = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adj_job_arbiter.md
Name: adj_job_arbiter

Overview:
- Scheduler and controller for one shared 12-bit adjust core.
- The core runs an INI/ADJ/DONE sequence with Start/Ack handshake, one-hot state outputs Qi/Qc/Qd, and result bus A.
- The block arbitrates round-robin among N requesters, launches each job on the core, and returns the result or a timeout error.
- A hung job is aborted through a dedicated core reset.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 256, maximum WAIT cycles before a job is aborted.
- CW, 9, timeout counter width; must satisfy 2^CW >= TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  N  per-requester job request; level, held until own Done.
- ReqAin  in  12*N  operand A; requester i occupies bits [12i+11:12i].
- ReqBin  in  12*N  operand B; same packing as ReqAin.
- Grant  out  N  one-hot; requester currently owning the core.
- Done  out  N  one-cycle pulse to the owner on job completion.
- Result  out  12  core result; valid in the cycle Done pulses, held until the next Done.
- Err  out  1  high with Done when the job was aborted by timeout.
- Busy  out  1  high whenever the state is not IDLE.
- CoreStart  out  1  to core Start.
- CoreAck  out  1  to core Ack.
- CoreReset  out  1  one-cycle abort pulse; top level ORs it with Reset into the core's Reset.
- CoreAin  out  12  to core Ain.
- CoreBin  out  12  to core Bin.
- CoreQi, CoreQc, CoreQd  in  1 each  core state outputs.
- CoreA  in  12  core result.

Behaviour:
- Reset (async): state=IDLE. Grant, Done, Err, Busy, CoreStart, CoreAck, CoreReset = 0. Result, CoreAin, CoreBin = 0. Round-robin pointer = requester 0 (highest priority after reset). Timeout counter = 0.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT, ACK, ABORT, DRAIN.
- IDLE:
  - If any Req bit is set, grant the first set bit found searching from pointer upward, wrapping modulo N.
  - Same edge: set Grant[idx]; latch that requester's operands into CoreAin/CoreBin; pointer <= idx+1 mod N; go to LAUNCH.
  - If no Req bit is set, stay in IDLE.
- LAUNCH:
  - CoreStart=1 for exactly this one cycle; counter cleared.
  - CoreAin/CoreBin stay stable from grant until the next grant.
  - Next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - If CoreQd=1: Result<=CoreA; Done[idx]<=1 for one cycle; Err<=0; CoreAck<=1 for one cycle; go to ACK.
  - Else if counter==TIMEOUT-1: go to ABORT.
  - If CoreQd=1 in the same cycle the counter reaches TIMEOUT-1, completion wins.
- ACK:
  - Wait for CoreQi=1, then clear Grant and go to IDLE.
  - A new grant cannot occur in the cycle Grant is cleared.
- ABORT:
  - CoreReset=1 for one cycle; Done[idx]=1 and Err=1 for one cycle; Result is unchanged.
  - Next state DRAIN.
- DRAIN: wait for CoreQi=1, then clear Grant and go to IDLE.
- Req handling:
  - Operands are sampled only at grant.
  - If Req[idx] deasserts mid-job, the job still completes and Done still pulses.
  - Req from other requesters during a job is ignored until IDLE.
- Latency: Done is asserted the cycle after the core reaches DONE.
- Reset mid-operation: the block returns to IDLE immediately. The core is reset by the same system Reset, so no stale Ack or Done is produced.

Test Plan:
1. Req=0001, Ain0=100, Bin0=300 -> CoreStart pulses once; core visits A=200, 300; Done=0001 with Result=300, Err=0; Grant clears after CoreQi; Busy returns to 0.
2. Req=0010, Ain1=100, Bin1=250 -> core overshoots to 300, then steps down by 10 to 250; Done=0010, Result=250, Err=0.
3. Req=1111 held, with small equal operands so every job finishes quickly -> grants issued in order 0,1,2,3,0; each Grant stays one-hot for the whole job; exactly one Done per job.
4. Req=0100, Ain2=4000, Bin2=4090 (12-bit wrap, runs longer than TIMEOUT=256) -> after 256 WAIT cycles CoreReset pulses; Done=0100 with Err=1; Result keeps its previous value; the next request completes normally.
5. Assert Reset during WAIT of a job from requester 3 -> all outputs 0 asynchronously; after release, Req=1000 is granted, with requester 0 holding priority if also requesting.
6. Force CoreQd=1 in the same cycle the counter reaches TIMEOUT-1 -> normal completion, Err=0, and CoreReset never asserts.
